// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer between the uart receiver and the CPU I/O read path.
// Circular buffer with registered pop data, a fill level and a sticky overflow flag.
module uart_rx_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  re,
  input  logic [WIDTH-1:0]      data_rx,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_BITS:0]   count,
  output logic                  overflow,
  input  logic                  clear_overflow
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0]   CNT_FULL = {1'b1, {DEPTH_BITS{1'b0}}};
  localparam logic [DEPTH_BITS:0]   CNT_ONE  = {{DEPTH_BITS{1'b0}}, 1'b1};
  localparam logic [DEPTH_BITS-1:0] PTR_ONE  = {{(DEPTH_BITS-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   count_q, count_d;
  logic [WIDTH-1:0]      rd_data_q, rd_data_d;
  logic                  rd_valid_q, ovf_q, ovf_d;
  logic                  empty_w, full_w, wr_accept, rd_accept;

  assign empty_w   = (count_q == '0);
  assign full_w    = (count_q == CNT_FULL);
  assign rd_accept = rd_en & ~empty_w;
  // A pop in the same cycle frees a slot, so a full buffer can still take the byte.
  assign wr_accept = re & (~full_w | rd_accept);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    ovf_d     = ovf_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_accept) begin
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
      rd_data_d = mem[rd_ptr_q];
    end
    if (wr_accept && !rd_accept)      count_d = count_q + CNT_ONE;
    else if (rd_accept && !wr_accept) count_d = count_q - CNT_ONE;
    // A drop takes priority over a simultaneous clear.
    if (re && !wr_accept)   ovf_d = 1'b1;
    else if (clear_overflow) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_accept;
      ovf_q      <= ovf_d;
    end
  end

  // Storage has no reset so it can map onto RAM; read of a full slot sees pre-write data.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr_q] <= data_rx;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign empty    = empty_w;
  assign full     = full_w;
  assign count    = count_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;

  logic       clk = 1'b0, reset = 1'b1;
  logic       re = 1'b0, rd_en = 1'b0, clear_overflow = 1'b0;
  logic [7:0] data_rx = 8'h00;
  logic [7:0] rd_data;
  logic       rd_valid, empty, full, overflow;
  logic [4:0] count;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.WIDTH(8), .DEPTH_BITS(4)) dut (
    .clk(clk), .reset(reset), .re(re), .data_rx(data_rx), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
    .count(count), .overflow(overflow), .clear_overflow(clear_overflow)
  );

  // Reference model: a byte queue with the acceptance rules applied directly.
  logic [7:0] mq[$];
  logic [7:0] m_rd_data = 8'h00;
  logic       m_rd_valid = 1'b0, m_ovf = 1'b0;
  bit         m_ra, m_wa;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_rd_data  = 8'h00;
      m_rd_valid = 1'b0;
      m_ovf      = 1'b0;
    end else begin
      m_ra = rd_en && (mq.size() != 0);
      m_wa = re && ((mq.size() < DEPTH) || m_ra);
      m_rd_valid = m_ra;
      if (m_ra) m_rd_data = mq.pop_front();
      if (m_wa) mq.push_back(data_rx);
      if (re && !m_wa) m_ovf = 1'b1;
      else if (clear_overflow) m_ovf = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("count",    32'(count),    32'(mq.size()));
    chk("empty",    32'(empty),    32'(mq.size() == 0));
    chk("full",     32'(full),     32'(mq.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
    chk("rd_data",  32'(rd_data),  32'(m_rd_data));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    re = 1'b1; data_rx = b;
    step();
    re = 1'b0;
  endtask

  task automatic pop_expect(input logic [7:0] b);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("pop_valid", 32'(rd_valid), 32'd1);
    chk("pop_data",  32'(rd_data),  32'(b));
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (10) step();
    reset = 1'b1;
    step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    chk("rst_data",  32'(rd_data), 32'd0);

    // single byte through
    push(8'h41);
    chk("t1_count", 32'(count), 32'd1);
    chk("t1_empty", 32'(empty), 32'd0);
    pop_expect(8'h41);
    chk("t1_empty2", 32'(empty), 32'd1);

    // fill, drop, drain
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("t2_full",  32'(full),  32'd1);
    chk("t2_count", 32'(count), 32'd16);
    push(8'hAA);
    chk("t2_ovf",   32'(overflow), 32'd1);
    chk("t2_count2", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) pop_expect(8'(i));
    chk("t2_empty", 32'(empty), 32'd1);
    clear_overflow = 1'b1; step(); clear_overflow = 1'b0;
    chk("t2_clr", 32'(overflow), 32'd0);

    // pointer wrap-around
    for (int i = 0; i < 10; i++) push(8'h20 + 8'(i));
    for (int i = 0; i < 10; i++) pop_expect(8'h20 + 8'(i));
    for (int i = 0; i < 16; i++) push(8'h30 + 8'(i));
    chk("t3_full", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) pop_expect(8'h30 + 8'(i));

    // write and read together while full
    for (int i = 0; i < 16; i++) push(8'h60 + 8'(i));
    re = 1'b1; data_rx = 8'h55; rd_en = 1'b1;
    step();
    re = 1'b0; rd_en = 1'b0;
    chk("t4_data",  32'(rd_data),  32'h60);
    chk("t4_count", 32'(count),    32'd16);
    chk("t4_ovf",   32'(overflow), 32'd0);
    for (int i = 1; i < 16; i++) pop_expect(8'h60 + 8'(i));
    pop_expect(8'h55);

    // write and read together while empty: no fall-through
    rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("t5_idle_valid", 32'(rd_valid), 32'd0);
    chk("t5_idle_hold",  32'(rd_data),  32'h55);
    re = 1'b1; data_rx = 8'h77; rd_en = 1'b1;
    step();
    re = 1'b0; rd_en = 1'b0;
    chk("t5_valid", 32'(rd_valid), 32'd0);
    chk("t5_count", 32'(count),    32'd1);
    pop_expect(8'h77);

    // overflow set beats clear, then clear alone
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
    push(8'hEE);
    chk("t6_ovf", 32'(overflow), 32'd1);
    re = 1'b1; data_rx = 8'hEF; clear_overflow = 1'b1;
    step();
    re = 1'b0;
    chk("t6_setwins", 32'(overflow), 32'd1);
    step();
    clear_overflow = 1'b0;
    chk("t6_cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 11; i++) pop_expect(8'h80 + 8'(i));
    chk("t6_count5", 32'(count), 32'd5);

    // asynchronous reset mid-stream
    reset = 1'b0;
    #1;
    chk("t6_arst_count", 32'(count), 32'd0);
    chk("t6_arst_empty", 32'(empty), 32'd1);
    chk("t6_arst_valid", 32'(rd_valid), 32'd0);
    repeat (3) step();
    reset = 1'b1;
    step();
    push(8'h99);
    pop_expect(8'h99);
    chk("t6_end_empty", 32'(empty), 32'd1);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
